ide_pio_ctrl: RTL and testbench
===============================

// Module: ide_pio_ctrl
// PURPOSE
//  Parametrised PIO-mode ATA/IDE bus sequencer; next generation of the fixed-PIO4 IDE block.
//  Arbitrates the DMA and Z80 channels (DMA has priority) and holds address, data and control
//  registered for the whole cycle. Runtime-programmable t1/t2/teoc cycle counts cover PIO0..4.
//  Supports optional IORDY wait-state extension with a timeout, and latches read data at the
//  end of the strobe.
// PARAMETERS
//  CNT_W    4   width of the t1/t2/teoc count inputs
//  TMO_W    8   width of the IORDY timeout counter; abort after 2**TMO_W-1 wait cycles
//  IORDY_EN 1   1: honour IORDY in STROBE; 0: ignore the iordy pin
// PORTS
//  clk          in   1      system clock (28 MHz)
//  reset_n      in   1      asynchronous active-low reset
//  t1_cyc       in   CNT_W  address-setup cycles (0 treated as 1)
//  t2_cyc       in   CNT_W  strobe-active cycles (0 treated as 1)
//  teoc_cyc     in   CNT_W  recovery cycles before CS release (0 treated as 1)
//  dma_req      in   1      DMA channel request; level
//  dma_rnw      in   1      DMA direction: 1 = read; DMA cycles always use a=0, cs0
//  dma_out      in   16     DMA write data
//  z80_req      in   1      Z80 channel request; level
//  z80_rnw      in   1      Z80 direction: 1 = read
//  z80_a        in   3      Z80 register address
//  z80_cs0_n    in   1      Z80 CS0 select
//  z80_cs1_n    in   1      Z80 CS1 select
//  z80_out      in   16     Z80 write data
//  ide_in       in   16     data bus from drive
//  iordy        in   1      drive IORDY; asynchronous
//  err_clr      in   1      clears err
//  rdy          out  1      1 = IDLE, ready to accept a request
//  rdy_stb      out  1      one-cycle pulse: transaction complete
//  done_dma     out  1      qualifies rdy_stb: completed cycle was DMA
//  rd_data      out  16     latched read data; valid from rdy_stb until the next read
//  err          out  1      sticky IORDY timeout flag
//  ide_out      out  16     registered write data to drive
//  ide_a        out  3      registered address
//  ide_dir      out  1      1 = read / bus released (rnw)
//  ide_cs0_n    out  1      CS0
//  ide_cs1_n    out  1      CS1
//  ide_rd_n     out  1      DIOR
//  ide_wr_n     out  1      DIOW
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; ide_dir=1; all cs/rd/wr_n=1; ide_a=0; ide_out=0;
//  rd_data=0; err=0; rdy_stb=0; done_dma=0. Counters are cleared.
//  iordy: 2-FF synchroniser, reset to 1. Internal iordy_s = IORDY_EN ? sync : 1.
//  FSM IDLE -> SETUP -> STROBE -> RECOVER -> IDLE; one down-counter cnt loaded per state.
//  IDLE, on a request:
//   - DMA wins if both request. Capture dir, a, cs, write data and t1/t2/teoc.
//   - Drive ide_a, ide_out, ide_dir and cs_n on the next edge. Load cnt=max(t1,1)-1. Go SETUP.
//   - Timing inputs are used only as captured; later changes do not affect the cycle in flight.
//  SETUP: at cnt==0, assert rd_n (read) or wr_n (write), load cnt=max(t2,1)-1, go STROBE.
//  STROBE:
//   - cnt counts down to 0, then holds while iordy_s==0; tmo increments on each held cycle.
//   - cnt==0 && iordy_s: deassert rd/wr_n; on a read, rd_data<=ide_in on the same edge.
//     Load cnt=max(teoc,1)-1, clear tmo, go RECOVER.
//   - tmo reaches all-ones: abort. Deassert the strobe, set err=1, rd_data<=16'hFFFF on a read,
//     go RECOVER.
//  RECOVER: at cnt==0, set cs0_n=cs1_n=1 and ide_dir=1, pulse rdy_stb for one cycle,
//  set done_dma, go IDLE.
//  rdy is combinational (state==IDLE). It is low from the first cycle after accept until the
//  edge that returns to IDLE. A request held across rdy_stb starts a new cycle on the
//  following edge (back-to-back).
//  ide_a and ide_out stay stable from the accept edge to the cs release edge; they hold their
//  last value in IDLE.
//  Cycle length without waits, accept edge to rdy: t1+t2+teoc (default 1+2+2 = 5, PIO4).
//  err_clr: clears err unless a timeout sets it in the same cycle (set wins).
//  Requests dropped mid-cycle are ignored; the cycle always completes.
// TESTING
//  z80 read a=7 cs0, t=1/2/2, ide_in=16'h0050 -> rd_n low 2 cycles; rdy_stb 5 cycles after accept;
//   rd_data=16'h0050, done_dma=0.
//  z80 write 16'h1234 a=2, t=3/8/4 (PIO0-like) -> wr_n low 8 cycles;
//   ide_out=16'h1234 stable until cs release; total 15 cycles.
//  dma_req and z80_req in the same cycle -> DMA served first (a=0, cs0_n=0, cs1_n=1), then Z80
//   back-to-back; done_dma=1 then 0.
//  iordy low 3 cycles in STROBE (IORDY_EN=1) -> strobe extended by exactly 3 cycles (after 2-FF
//   sync); err=0. With IORDY_EN=0 -> no extension.
//  iordy stuck low, TMO_W=4 -> abort after 15 wait cycles; err=1; rd_data=16'hFFFF; rdy_stb fires;
//   err_clr -> err=0.
//  reset_n low mid-STROBE -> all control outputs 1 immediately (async); rdy=1 after release.
//   t1/t2/teoc=0 -> behaves as 1/1/1.

Source files
------------

// File: rtl/ide_pio_ctrl.sv
// PIO-mode ATA/IDE bus sequencer: arbitrates DMA (priority) and Z80 requests into one registered IDE cycle.
// Latency: accept edge to rdy/rdy_stb is t1+t2+teoc cycles (counts of 0 act as 1), plus any IORDY wait cycles.
// Backpressure: rdy is low for the whole cycle; requests are level-held and sampled only in IDLE.
module ide_pio_ctrl #(
    parameter int CNT_W    = 4,
    parameter int TMO_W    = 8,
    parameter bit IORDY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] t1_cyc,
    input  logic [CNT_W-1:0] t2_cyc,
    input  logic [CNT_W-1:0] teoc_cyc,
    input  logic             dma_req,
    input  logic             dma_rnw,
    input  logic [15:0]      dma_out,
    input  logic             z80_req,
    input  logic             z80_rnw,
    input  logic [2:0]       z80_a,
    input  logic             z80_cs0_n,
    input  logic             z80_cs1_n,
    input  logic [15:0]      z80_out,
    input  logic [15:0]      ide_in,
    input  logic             iordy,
    input  logic             err_clr,
    output logic             rdy,
    output logic             rdy_stb,
    output logic             done_dma,
    output logic [15:0]      rd_data,
    output logic             err,
    output logic [15:0]      ide_out,
    output logic [2:0]       ide_a,
    output logic             ide_dir,
    output logic             ide_cs0_n,
    output logic             ide_cs1_n,
    output logic             ide_rd_n,
    output logic             ide_wr_n
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic [TMO_W-1:0] tmo_inc;
    logic [CNT_W-1:0] cap_t2, cap_t2_nxt;
    logic [CNT_W-1:0] cap_teoc, cap_teoc_nxt;
    logic             cap_rnw, cap_rnw_nxt;
    logic             cap_dma, cap_dma_nxt;

    logic [15:0] ide_out_nxt, rd_data_nxt;
    logic [2:0]  ide_a_nxt;
    logic        ide_dir_nxt, ide_cs0_n_nxt, ide_cs1_n_nxt, ide_rd_n_nxt, ide_wr_n_nxt;
    logic        err_nxt, rdy_stb_nxt, done_dma_nxt;

    logic iordy_ff1, iordy_ff2, iordy_s;

    // A programmed count of N gives N cycles in the phase; zero is stretched to one cycle.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign iordy_s = IORDY_EN ? iordy_ff2 : 1'b1;
    assign tmo_inc = tmo + TMO_W'(1);
    assign rdy     = (state == S_IDLE);

    // Two-stage synchroniser for the drive's asynchronous IORDY; idles high (ready).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iordy_ff1 <= 1'b1;
            iordy_ff2 <= 1'b1;
        end else begin
            iordy_ff1 <= iordy;
            iordy_ff2 <= iordy_ff1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state, phase counter, wait timeout and next values of every registered bus output.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmo_nxt       = tmo;
        cap_t2_nxt    = cap_t2;
        cap_teoc_nxt  = cap_teoc;
        cap_rnw_nxt   = cap_rnw;
        cap_dma_nxt   = cap_dma;
        ide_out_nxt   = ide_out;
        ide_a_nxt     = ide_a;
        ide_dir_nxt   = ide_dir;
        ide_cs0_n_nxt = ide_cs0_n;
        ide_cs1_n_nxt = ide_cs1_n;
        ide_rd_n_nxt  = ide_rd_n;
        ide_wr_n_nxt  = ide_wr_n;
        rd_data_nxt   = rd_data;
        done_dma_nxt  = done_dma;
        rdy_stb_nxt   = 1'b0;
        // a timeout abort later in this block overrides the clear
        err_nxt       = err_clr ? 1'b0 : err;

        unique case (state)
            S_IDLE: begin
                if (dma_req || z80_req) begin
                    // DMA always targets the data register (a=0 on CS0)
                    cap_dma_nxt   = dma_req;
                    cap_rnw_nxt   = dma_req ? dma_rnw : z80_rnw;
                    ide_dir_nxt   = dma_req ? dma_rnw : z80_rnw;
                    ide_a_nxt     = dma_req ? 3'd0    : z80_a;
                    ide_cs0_n_nxt = dma_req ? 1'b0    : z80_cs0_n;
                    ide_cs1_n_nxt = dma_req ? 1'b1    : z80_cs1_n;
                    ide_out_nxt   = dma_req ? dma_out : z80_out;
                    cap_t2_nxt    = t2_cyc;
                    cap_teoc_nxt  = teoc_cyc;
                    cnt_nxt       = load_cnt(t1_cyc);
                    tmo_nxt       = '0;
                    state_nxt     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    ide_rd_n_nxt = ~cap_rnw;
                    ide_wr_n_nxt = cap_rnw;
                    cnt_nxt      = load_cnt(cap_t2);
                    state_nxt    = S_STROBE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (iordy_s) begin
                    ide_rd_n_nxt = 1'b1;
                    ide_wr_n_nxt = 1'b1;
                    if (cap_rnw) rd_data_nxt = ide_in;
                    cnt_nxt   = load_cnt(cap_teoc);
                    tmo_nxt   = '0;
                    state_nxt = S_RECOVER;
                end else if (&tmo_inc) begin
                    // drive never became ready: end the strobe and flag it
                    ide_rd_n_nxt = 1'b1;
                    ide_wr_n_nxt = 1'b1;
                    err_nxt      = 1'b1;
                    if (cap_rnw) rd_data_nxt = 16'hFFFF;
                    cnt_nxt   = load_cnt(cap_teoc);
                    tmo_nxt   = '0;
                    state_nxt = S_RECOVER;
                end else begin
                    tmo_nxt = tmo_inc;
                end
            end
            S_RECOVER: begin
                if (cnt == '0) begin
                    ide_cs0_n_nxt = 1'b1;
                    ide_cs1_n_nxt = 1'b1;
                    ide_dir_nxt   = 1'b1;
                    rdy_stb_nxt   = 1'b1;
                    done_dma_nxt  = cap_dma;
                    state_nxt     = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and bus-output registers; the bus idles released (dir=1, all strobes/selects high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            tmo       <= '0;
            cap_t2    <= '0;
            cap_teoc  <= '0;
            cap_rnw   <= 1'b1;
            cap_dma   <= 1'b0;
            ide_out   <= '0;
            ide_a     <= '0;
            ide_dir   <= 1'b1;
            ide_cs0_n <= 1'b1;
            ide_cs1_n <= 1'b1;
            ide_rd_n  <= 1'b1;
            ide_wr_n  <= 1'b1;
            rd_data   <= '0;
            err       <= 1'b0;
            rdy_stb   <= 1'b0;
            done_dma  <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            tmo       <= tmo_nxt;
            cap_t2    <= cap_t2_nxt;
            cap_teoc  <= cap_teoc_nxt;
            cap_rnw   <= cap_rnw_nxt;
            cap_dma   <= cap_dma_nxt;
            ide_out   <= ide_out_nxt;
            ide_a     <= ide_a_nxt;
            ide_dir   <= ide_dir_nxt;
            ide_cs0_n <= ide_cs0_n_nxt;
            ide_cs1_n <= ide_cs1_n_nxt;
            ide_rd_n  <= ide_rd_n_nxt;
            ide_wr_n  <= ide_wr_n_nxt;
            rd_data   <= rd_data_nxt;
            err       <= err_nxt;
            rdy_stb   <= rdy_stb_nxt;
            done_dma  <= done_dma_nxt;
        end
    end

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Bench for ide_pio_ctrl: timeline model of each bus cycle checked every cycle, plus directed literal checks.
// Latency: not applicable (testbench).
// Backpressure: requests are raised only while rdy is high and held until the accept edge.
module tb_ide_pio_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO_W = 4;
    localparam int WMAX  = 2**TMO_W - 1;

    logic clk = 1'b0;
    logic reset_n;
    logic [CNT_W-1:0] t1_cyc, t2_cyc, teoc_cyc;
    logic dma_req, dma_rnw, z80_req, z80_rnw, z80_cs0_n, z80_cs1_n, iordy, err_clr;
    logic [15:0] dma_out, z80_out, ide_in;
    logic [2:0] z80_a;

    logic rdy, rdy_stb, done_dma, err, ide_dir, ide_cs0_n, ide_cs1_n, ide_rd_n, ide_wr_n;
    logic [15:0] rd_data, ide_out;
    logic [2:0] ide_a;

    logic rdy_2, rdy_stb_2, done_dma_2, err_2, ide_dir_2, ide_cs0_n_2, ide_cs1_n_2, ide_rd_n_2, ide_wr_n_2;
    logic [15:0] rd_data_2, ide_out_2;
    logic [2:0] ide_a_2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ide_pio_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W), .IORDY_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .t1_cyc(t1_cyc), .t2_cyc(t2_cyc), .teoc_cyc(teoc_cyc),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_out(dma_out),
        .z80_req(z80_req), .z80_rnw(z80_rnw), .z80_a(z80_a), .z80_cs0_n(z80_cs0_n),
        .z80_cs1_n(z80_cs1_n), .z80_out(z80_out), .ide_in(ide_in), .iordy(iordy), .err_clr(err_clr),
        .rdy(rdy), .rdy_stb(rdy_stb), .done_dma(done_dma), .rd_data(rd_data), .err(err),
        .ide_out(ide_out), .ide_a(ide_a), .ide_dir(ide_dir), .ide_cs0_n(ide_cs0_n),
        .ide_cs1_n(ide_cs1_n), .ide_rd_n(ide_rd_n), .ide_wr_n(ide_wr_n));

    // Same stimulus, IORDY ignored.
    ide_pio_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W), .IORDY_EN(1'b0)) dut_noio (
        .clk(clk), .reset_n(reset_n), .t1_cyc(t1_cyc), .t2_cyc(t2_cyc), .teoc_cyc(teoc_cyc),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_out(dma_out),
        .z80_req(z80_req), .z80_rnw(z80_rnw), .z80_a(z80_a), .z80_cs0_n(z80_cs0_n),
        .z80_cs1_n(z80_cs1_n), .z80_out(z80_out), .ide_in(ide_in), .iordy(iordy), .err_clr(err_clr),
        .rdy(rdy_2), .rdy_stb(rdy_stb_2), .done_dma(done_dma_2), .rd_data(rd_data_2), .err(err_2),
        .ide_out(ide_out_2), .ide_a(ide_a_2), .ide_dir(ide_dir_2), .ide_cs0_n(ide_cs0_n_2),
        .ide_cs1_n(ide_cs1_n_2), .ide_rd_n(ide_rd_n_2), .ide_wr_n(ide_wr_n_2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A cycle is described by edge offsets from the accept edge: strobe on at edge S,
    // strobe off at edge 'm_end' (first edge >= S+t2 that sees synchronised IORDY high,
    // or the 15th waiting edge), chip selects released at edge m_end+R.
    bit          m_active, m_stb, m_rnw, m_dma, m_cs0, m_cs1, m_err, m_done, m_p1, m_p2, ios;
    int          m_k, m_S, m_t2, m_R, m_end, m_waits;
    logic [2:0]  m_a;
    logic [15:0] m_out, m_rd;

    function automatic int at_least_one(input logic [CNT_W-1:0] t);
        return (t == 0) ? 1 : int'(t);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_stb = 0; m_rnw = 1; m_dma = 0; m_cs0 = 1; m_cs1 = 1;
            m_err = 0; m_done = 0; m_p1 = 1; m_p2 = 1; m_a = '0; m_out = '0; m_rd = '0;
            m_k = 0; m_end = -1; m_waits = 0;
        end else begin
            ios  = m_p2;          // pin as sampled two edges ago
            m_p2 = m_p1;
            m_p1 = iordy;
            m_stb = 0;
            if (m_active) begin
                m_k++;
                if (m_end < 0 && m_k >= m_S + m_t2) begin
                    if (ios) begin
                        m_end = m_k;
                        if (m_rnw) m_rd = ide_in;
                        if (err_clr) m_err = 0;
                    end else begin
                        m_waits++;
                        if (m_waits == WMAX) begin
                            m_end = m_k;
                            m_err = 1;
                            if (m_rnw) m_rd = 16'hFFFF;
                        end else if (err_clr) m_err = 0;
                    end
                end else begin
                    if (err_clr) m_err = 0;
                    if (m_end >= 0 && m_k == m_end + m_R) begin
                        m_active = 0;
                        m_stb    = 1;
                        m_done   = m_dma;
                    end
                end
            end else begin
                if (err_clr) m_err = 0;
                if (dma_req || z80_req) begin
                    m_active = 1; m_k = 0; m_end = -1; m_waits = 0;
                    m_dma = dma_req;
                    m_rnw = dma_req ? dma_rnw : z80_rnw;
                    m_a   = dma_req ? 3'd0 : z80_a;
                    m_cs0 = dma_req ? 1'b0 : z80_cs0_n;
                    m_cs1 = dma_req ? 1'b1 : z80_cs1_n;
                    m_out = dma_req ? dma_out : z80_out;
                    m_S   = at_least_one(t1_cyc);
                    m_t2  = at_least_one(t2_cyc);
                    m_R   = at_least_one(teoc_cyc);
                end
            end
        end
    end

    // Compare every output of the IORDY-honouring instance against the model on each falling edge.
    always @(negedge clk) begin
        bit strobe;
        strobe = m_active && (m_k >= m_S) && (m_end < 0);
        check("rdy",      rdy,       !m_active);
        check("rdy_stb",  rdy_stb,   m_stb);
        check("done_dma", done_dma,  m_done);
        check("rd_data",  rd_data,   m_rd);
        check("err",      err,       m_err);
        check("ide_out",  ide_out,   m_out);
        check("ide_a",    ide_a,     m_a);
        check("ide_dir",  ide_dir,   m_active ? m_rnw : 1'b1);
        check("cs0_n",    ide_cs0_n, m_active ? m_cs0 : 1'b1);
        check("cs1_n",    ide_cs1_n, m_active ? m_cs1 : 1'b1);
        check("rd_n",     ide_rd_n,  !(strobe && m_rnw));
        check("wr_n",     ide_wr_n,  !(strobe && !m_rnw));
    end

    // ---------------- stimulus ----------------
    // Issues one request at a falling edge; iordy is held low for offsets [lo_s, lo_s+lo_l)
    // where offset -1 is the cycle before the accept edge. Reports strobe length and the
    // offsets at which each instance pulsed rdy_stb (-1 = never).
    task automatic do_txn(input bit use_dma, input bit rnw, input logic [2:0] a, input bit c0,
                          input bit c1, input logic [15:0] dat, input logic [3:0] t1,
                          input logic [3:0] t2, input logic [3:0] te, input int lo_s, input int lo_l,
                          output int stb_at, output int stb2_at, output int slen);
        int g;
        g = 0;
        while (!rdy && g < 100) begin @(negedge clk); g++; end
        check("rdy_before_req", rdy, 1'b1);
        t1_cyc = t1; t2_cyc = t2; teoc_cyc = te;
        if (use_dma) begin
            dma_req = 1; dma_rnw = rnw; dma_out = dat;
        end else begin
            z80_req = 1; z80_rnw = rnw; z80_a = a; z80_cs0_n = c0; z80_cs1_n = c1; z80_out = dat;
        end
        iordy = !(-1 >= lo_s && -1 < lo_s + lo_l);
        @(posedge clk);
        stb_at = -1; stb2_at = -1; slen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                dma_req = 0; z80_req = 0;
                // changing timing inputs mid-cycle must not affect the cycle in flight
                t1_cyc = 4'd9; t2_cyc = 4'd9; teoc_cyc = 4'd9;
            end
            if (!ide_rd_n || !ide_wr_n) slen++;
            if (rdy_stb && stb_at < 0) stb_at = k;
            if (rdy_stb_2 && stb2_at < 0) stb2_at = k;
            iordy = !(k >= lo_s && k < lo_s + lo_l);
            if (stb_at >= 0 && stb2_at >= 0) break;
        end
        iordy = 1;
    endtask

    task automatic wait_stb(input string name);
        int g;
        g = 0;
        while (!rdy_stb && g < 60) begin @(negedge clk); g++; end
        check(name, rdy_stb, 1'b1);
    endtask

    initial begin
        int sa, sb, sl;
        reset_n = 1; dma_req = 0; dma_rnw = 0; dma_out = '0; z80_req = 0; z80_rnw = 0;
        z80_a = '0; z80_cs0_n = 1; z80_cs1_n = 1; z80_out = '0; ide_in = '0; iordy = 1;
        err_clr = 0; t1_cyc = 4'd1; t2_cyc = 4'd2; teoc_cyc = 4'd2;
        #2 reset_n = 0;
        #1;
        check("rst_rdy", rdy, 1'b1);
        check("rst_dir", ide_dir, 1'b1);
        check("rst_cs0", ide_cs0_n, 1'b1);
        check("rst_rdn", ide_rd_n, 1'b1);
        check("rst_wrn", ide_wr_n, 1'b1);
        check("rst_rdd", rd_data, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        // PIO4 register read
        ide_in = 16'h0050;
        do_txn(0, 1, 3'd7, 0, 1, 16'h0000, 4'd1, 4'd2, 4'd2, 1000, 0, sa, sb, sl);
        check("rd_stb_at", sa, 5);
        check("rd_strobe_len", sl, 2);
        check("rd_data_val", rd_data, 16'h0050);
        check("rd_done_dma", done_dma, 1'b0);

        // PIO0-like write
        do_txn(0, 0, 3'd2, 0, 1, 16'h1234, 4'd3, 4'd8, 4'd4, 1000, 0, sa, sb, sl);
        check("wr_stb_at", sa, 15);
        check("wr_strobe_len", sl, 8);
        check("wr_ide_out", ide_out, 16'h1234);
        check("wr_ide_a", ide_a, 3'd2);

        // Simultaneous DMA and Z80 requests: DMA first, Z80 back-to-back
        t1_cyc = 4'd1; t2_cyc = 4'd1; teoc_cyc = 4'd1;
        dma_req = 1; dma_rnw = 0; dma_out = 16'hD1D1;
        z80_req = 1; z80_rnw = 1; z80_a = 3'd5; z80_cs0_n = 1; z80_cs1_n = 0; z80_out = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        dma_req = 0;
        check("b2b_dma_a", ide_a, 3'd0);
        check("b2b_dma_cs0", ide_cs0_n, 1'b0);
        check("b2b_dma_cs1", ide_cs1_n, 1'b1);
        check("b2b_dma_out", ide_out, 16'hD1D1);
        wait_stb("b2b_dma_stb");
        check("b2b_dma_done", done_dma, 1'b1);
        @(negedge clk);
        z80_req = 0;
        check("b2b_z80_busy", rdy, 1'b0);
        check("b2b_z80_a", ide_a, 3'd5);
        check("b2b_z80_cs1", ide_cs1_n, 1'b0);
        wait_stb("b2b_z80_stb");
        check("b2b_z80_done", done_dma, 1'b0);

        // IORDY low for three cycles: strobe stretched by exactly three
        ide_in = 16'hBEEF;
        do_txn(0, 1, 3'd0, 0, 1, 16'h0000, 4'd1, 4'd2, 4'd2, 0, 3, sa, sb, sl);
        check("wait_strobe_len", sl, 5);
        check("wait_stb_at", sa, 8);
        check("wait_noio_stb_at", sb, 5);
        check("wait_err", err, 1'b0);
        check("wait_rd_data", rd_data, 16'hBEEF);

        // IORDY stuck low: abort after 15 wait cycles
        ide_in = 16'h0123;
        do_txn(0, 1, 3'd1, 0, 1, 16'h0000, 4'd1, 4'd1, 4'd1, -1, 1000, sa, sb, sl);
        check("tmo_strobe_len", sl, 15);
        check("tmo_stb_at", sa, 17);
        check("tmo_err", err, 1'b1);
        check("tmo_rd_data", rd_data, 16'hFFFF);
        check("tmo_noio_stb_at", sb, 3);
        check("tmo_noio_err", err_2, 1'b0);
        check("tmo_noio_rd_data", rd_data_2, 16'h0123);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("tmo_err_clr", err, 1'b0);

        // Zero timing counts behave as 1/1/1
        do_txn(1, 0, 3'd0, 0, 1, 16'hA5A5, 4'd0, 4'd0, 4'd0, 1000, 0, sa, sb, sl);
        check("zero_stb_at", sa, 3);
        check("zero_strobe_len", sl, 1);
        check("zero_done_dma", done_dma, 1'b1);

        // Asynchronous reset in the middle of the strobe
        t1_cyc = 4'd1; t2_cyc = 4'd4; teoc_cyc = 4'd2;
        z80_req = 1; z80_rnw = 1; z80_a = 3'd3; z80_cs0_n = 0; z80_cs1_n = 1;
        @(posedge clk);
        @(negedge clk);
        z80_req = 0;
        @(negedge clk);
        check("mid_rd_low", ide_rd_n, 1'b0);
        #2 reset_n = 0;
        #1;
        check("arst_rdn", ide_rd_n, 1'b1);
        check("arst_cs0", ide_cs0_n, 1'b1);
        check("arst_dir", ide_dir, 1'b1);
        check("arst_rdy", rdy, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check("post_rst_rdy", rdy, 1'b1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, got still running, expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
